// File: rtl/cpu10_ex_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cpu10_ex_mem_wb_pipe
//  Brief    : Execute/memory/write-back half of the 10-bit CPU pipeline,
//             with optional WB->EM bypass (macro FORWARDING_EN) and the
//             sticky halt flag.
//  Revision : 1.0  initial release
// ============================================================================
module cpu10_ex_mem_wb_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] fd_op_a,
    input  logic [9:0] fd_op_b,
    input  logic [2:0] fd_alu_ctrl,
    input  logic       fd_reg_we,
    input  logic       fd_mem_we,
    input  logic       fd_mem_re,
    input  logic [9:0] fd_store_data,
    input  logic [2:0] fd_src_a,
    input  logic [2:0] fd_src_b,
    input  logic       fd_b_is_reg,
    input  logic [9:0] mem_rdata,
    output logic [9:0] mem_addr,
    output logic [9:0] mem_wdata,
    output logic       mem_we,
    output logic       wb_we,
    output logic [2:0] wb_dest,
    output logic [9:0] wb_wdata,
    output logic       halted
);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_NAND = 3'b011;
    localparam logic [2:0] ALU_SLR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_HALT = 3'b110;

    logic [9:0] em_op_a_q, em_op_a_d, em_op_b_q, em_op_b_d;
    logic [2:0] em_alu_ctrl_q, em_alu_ctrl_d;
    logic       em_reg_we_q, em_reg_we_d, em_mem_we_q, em_mem_we_d;
    logic       em_mem_re_q, em_mem_re_d, em_b_is_reg_q, em_b_is_reg_d;
    logic [9:0] em_store_q, em_store_d;
    logic [2:0] em_src_a_q, em_src_a_d, em_src_b_q, em_src_b_d;

    logic [9:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
    logic       wb_reg_we_q, wb_reg_we_d, wb_mem_re_q, wb_mem_re_d;
    logic [2:0] wb_dest_q, wb_dest_d;
    logic       halted_q, halted_d;

    logic [9:0] alu_a, alu_b, store_val, alu_res, wb_wdata_w;
    logic [3:0] shamt;
    logic       alu_halt;

    assign wb_wdata_w = wb_mem_re_q ? wb_rdata_q : wb_alu_q;

    // Operand selection: latched values, optionally bypassed from WB.
    always_comb begin
        alu_a     = em_op_a_q;
        alu_b     = em_op_b_q;
        store_val = em_store_q;
`ifdef FORWARDING_EN
        if (wb_reg_we_q && (wb_dest_q == em_src_a_q))
            alu_a = wb_wdata_w;
        if (wb_reg_we_q && (wb_dest_q == em_src_b_q) && em_b_is_reg_q)
            alu_b = wb_wdata_w;
        if (wb_reg_we_q && (wb_dest_q == em_src_b_q))
            store_val = wb_wdata_w;
`endif
    end

`ifndef FORWARDING_EN
    logic unused_fwd_fields;
    assign unused_fwd_fields = ^{em_src_a_q, em_b_is_reg_q};
`endif

    always_comb begin
        alu_res  = '0;
        alu_halt = 1'b0;
        shamt    = alu_b[3:0];
        case (em_alu_ctrl_q)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_SLT:  alu_res = {9'd0, ($signed(alu_a) < $signed(alu_b))};
            ALU_NAND: alu_res = ~(alu_a & alu_b);
            ALU_SLR:  alu_res = (shamt >= 4'd10) ? 10'd0 : (alu_a >> shamt);
            ALU_SLL:  alu_res = (shamt >= 4'd10) ? 10'd0 : (alu_a << shamt);
            ALU_HALT: alu_halt = 1'b1;
            default:  alu_res = '0;
        endcase
    end

    // A HALT in EM already blocks the instruction behind it from entering.
    always_comb begin
        em_op_a_d     = fd_op_a;
        em_op_b_d     = fd_op_b;
        em_alu_ctrl_d = fd_alu_ctrl;
        em_reg_we_d   = fd_reg_we;
        em_mem_we_d   = fd_mem_we;
        em_mem_re_d   = fd_mem_re;
        em_store_d    = fd_store_data;
        em_src_a_d    = fd_src_a;
        em_src_b_d    = fd_src_b;
        em_b_is_reg_d = fd_b_is_reg;
        if (halted_q || alu_halt) begin
            em_op_a_d     = '0;
            em_op_b_d     = '0;
            em_alu_ctrl_d = '0;
            em_reg_we_d   = 1'b0;
            em_mem_we_d   = 1'b0;
            em_mem_re_d   = 1'b0;
            em_store_d    = '0;
            em_src_a_d    = '0;
            em_src_b_d    = '0;
            em_b_is_reg_d = 1'b0;
        end
        wb_alu_d    = alu_res;
        wb_rdata_d  = mem_rdata;
        wb_reg_we_d = em_reg_we_q;
        wb_mem_re_d = em_mem_re_q;
        wb_dest_d   = em_src_b_q;
        halted_d    = halted_q | alu_halt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            em_op_a_q     <= '0;
            em_op_b_q     <= '0;
            em_alu_ctrl_q <= '0;
            em_reg_we_q   <= 1'b0;
            em_mem_we_q   <= 1'b0;
            em_mem_re_q   <= 1'b0;
            em_store_q    <= '0;
            em_src_a_q    <= '0;
            em_src_b_q    <= '0;
            em_b_is_reg_q <= 1'b0;
            wb_alu_q      <= '0;
            wb_rdata_q    <= '0;
            wb_reg_we_q   <= 1'b0;
            wb_mem_re_q   <= 1'b0;
            wb_dest_q     <= '0;
            halted_q      <= 1'b0;
        end else begin
            em_op_a_q     <= em_op_a_d;
            em_op_b_q     <= em_op_b_d;
            em_alu_ctrl_q <= em_alu_ctrl_d;
            em_reg_we_q   <= em_reg_we_d;
            em_mem_we_q   <= em_mem_we_d;
            em_mem_re_q   <= em_mem_re_d;
            em_store_q    <= em_store_d;
            em_src_a_q    <= em_src_a_d;
            em_src_b_q    <= em_src_b_d;
            em_b_is_reg_q <= em_b_is_reg_d;
            wb_alu_q      <= wb_alu_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_reg_we_q   <= wb_reg_we_d;
            wb_mem_re_q   <= wb_mem_re_d;
            wb_dest_q     <= wb_dest_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr  = alu_res;
    assign mem_we    = em_mem_we_q;
    assign mem_wdata = em_mem_we_q ? store_val : 10'd0;
    assign wb_we     = wb_reg_we_q;
    assign wb_dest   = wb_dest_q;
    assign wb_wdata  = wb_wdata_w;
    assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu10_ex_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu10_ex_mem_wb_pipe
//  Brief    : Self-checking bench for cpu10_ex_mem_wb_pipe against a
//             transaction-level reference model and a data-memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu10_ex_mem_wb_pipe;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] op_a;
        logic [9:0] op_b;
        logic [2:0] ctrl;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic [9:0] sdata;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic       b_reg;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] fd_op_a = '0, fd_op_b = '0, fd_store_data = '0;
    logic [2:0] fd_alu_ctrl = '0, fd_src_a = '0, fd_src_b = '0;
    logic       fd_reg_we = 1'b0, fd_mem_we = 1'b0, fd_mem_re = 1'b0, fd_b_is_reg = 1'b0;
    logic [9:0] mem_rdata, mem_addr, mem_wdata, wb_wdata;
    logic       mem_we, wb_we, halted;
    logic [2:0] wb_dest;

    logic [9:0] mem     [1024];
    logic [9:0] ref_mem [1024];

    instr_t     m_em;
    logic       m_wb_we, m_h;
    logic [2:0] m_wb_dest;
    logic [9:0] m_wb_data;
    logic [35:0] exp_v;
    logic [35:0] act_v;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign act_v = {mem_addr, mem_wdata, mem_we, wb_we, wb_dest, wb_wdata, halted};

    cpu10_ex_mem_wb_pipe dut (
        .clk(clk), .rst(rst),
        .fd_op_a(fd_op_a), .fd_op_b(fd_op_b), .fd_alu_ctrl(fd_alu_ctrl),
        .fd_reg_we(fd_reg_we), .fd_mem_we(fd_mem_we), .fd_mem_re(fd_mem_re),
        .fd_store_data(fd_store_data), .fd_src_a(fd_src_a), .fd_src_b(fd_src_b),
        .fd_b_is_reg(fd_b_is_reg), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .wb_we(wb_we), .wb_dest(wb_dest), .wb_wdata(wb_wdata), .halted(halted)
    );

    // Instruction-set semantics in plain integer arithmetic.
    function automatic logic [9:0] ref_alu(input logic [2:0] c, input logic [9:0] a, input logic [9:0] b);
        int ia, ib, sh;
        ia = int'(a);
        ib = int'(b);
        sh = ib % 16;
        case (c)
            3'd0: return 10'((ia + ib) % 1024);
            3'd1: return 10'((ia - ib + 1024) % 1024);
            3'd2: begin
                if (ia >= 512) ia -= 1024;
                if (ib >= 512) ib -= 1024;
                return (ia < ib) ? 10'd1 : 10'd0;
            end
            3'd3: return 10'(1023 - (ia & ib));
            3'd4: return (sh >= 10) ? 10'd0 : 10'(ia / (1 << sh));
            3'd5: return (sh >= 10) ? 10'd0 : 10'((ia * (1 << sh)) % 1024);
            default: return 10'd0;
        endcase
    endfunction

    function automatic void em_eval(input instr_t e, output logic [9:0] res, output logic [9:0] sd);
        logic [9:0] a, b;
        a  = e.op_a;
        b  = e.op_b;
        sd = e.sdata;
        if (FWD && m_wb_we && m_wb_dest == e.src_a) a = m_wb_data;
        if (FWD && m_wb_we && m_wb_dest == e.src_b && e.b_reg) b = m_wb_data;
        if (FWD && m_wb_we && m_wb_dest == e.src_b) sd = m_wb_data;
        res = ref_alu(e.ctrl, a, b);
    endfunction

    // One clock: present f with reset level rn, advance model and DUT, set exp_v.
    task automatic step(input instr_t f, input logic rn);
        logic       pw, stopped;
        logic [9:0] pa, pd, r, s, ld;
        @(negedge clk);
        fd_op_a = f.op_a; fd_op_b = f.op_b; fd_alu_ctrl = f.ctrl;
        fd_reg_we = f.reg_we; fd_mem_we = f.mem_we; fd_mem_re = f.mem_re;
        fd_store_data = f.sdata; fd_src_a = f.src_a; fd_src_b = f.src_b;
        fd_b_is_reg = f.b_reg; rst = rn;
        pw = mem_we; pa = mem_addr; pd = mem_wdata;
        em_eval(m_em, r, s);
        ld = ref_mem[r];
        if (m_em.mem_we) ref_mem[r] = s;
        if (!rn) begin
            m_em = '0; m_wb_we = 1'b0; m_wb_dest = '0; m_wb_data = '0; m_h = 1'b0;
        end else begin
            stopped   = m_h || (m_em.ctrl == 3'd6);
            m_wb_we   = m_em.reg_we;
            m_wb_dest = m_em.src_b;
            m_wb_data = m_em.mem_re ? ld : r;
            m_em      = stopped ? '0 : f;
            m_h       = stopped;
        end
        @(posedge clk);
        #1;
        if (pw === 1'b1) mem[pa] = pd;
        em_eval(m_em, r, s);
        exp_v = {r, (m_em.mem_we ? s : 10'd0), m_em.mem_we, m_wb_we, m_wb_dest, m_wb_data, m_h};
    endtask

    function automatic instr_t mk(input logic [2:0] c, input logic [9:0] a, input logic [9:0] b,
                                  input logic rw, input logic [2:0] sa, input logic [2:0] sb);
        instr_t t;
        t = '0;
        t.ctrl = c; t.op_a = a; t.op_b = b; t.reg_we = rw; t.src_a = sa; t.src_b = sb;
        return t;
    endfunction

    task automatic test_reset();
        step('0, 1'b0);
        step('0, 1'b0);
        total++;
        if (act_v !== 36'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", act_v, 36'd0);
        end
        total++;
        if (act_v !== exp_v) begin
            bad++; $display("FAIL reset_model got=%h exp=%h", act_v, exp_v);
        end
        step('0, 1'b1);
    endtask

    task automatic test_alu();
        logic [2:0] ct [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
        logic [9:0] av [6] = '{10'd5, 10'd2, 10'h3FF, 10'h3FF, 10'd1, 10'h200};
        logic [9:0] bv [6] = '{10'd3, 10'd3, 10'd1, 10'h3FF, 10'd9, 10'd12};
        logic [9:0] rv [6] = '{10'd8, 10'h3FF, 10'd1, 10'd0, 10'h200, 10'd0};
        for (int i = 0; i < 6; i++) begin
            step(mk(ct[i], av[i], bv[i], 1'b1, 3'd7, 3'(i)), 1'b1);
            total++;
            if (mem_addr !== rv[i]) begin
                bad++; $display("FAIL alu_op%0d mem_addr got=%h exp=%h", ct[i], mem_addr, rv[i]);
            end
            if (i == 1) begin
                total++;
                if ({wb_we, wb_dest, wb_wdata} !== {1'b1, 3'd0, 10'd8}) begin
                    bad++; $display("FAIL add_writeback got=%h exp=%h", {wb_we, wb_dest, wb_wdata}, {1'b1, 3'd0, 10'd8});
                end
            end
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL alu_model%0d got=%h exp=%h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] want;
        want = FWD ? 10'd9 : 10'd1;
        step('0, 1'b1);
        step(mk(3'd0, 10'd4, 10'd4, 1'b1, 3'd6, 3'd1), 1'b1);
        step(mk(3'd0, 10'd0, 10'd1, 1'b1, 3'd1, 3'd2), 1'b1);
        total++;
        if (mem_addr !== want) begin
            bad++; $display("FAIL back_to_back got=%h exp=%h", mem_addr, want);
        end
    endtask

    task automatic test_store_load();
        instr_t st, ldi;
        step('0, 1'b1);
        st = mk(3'd0, 10'd6, 10'd0, 1'b0, 3'd6, 3'd5);
        st.mem_we = 1'b1; st.sdata = 10'h2A;
        step(st, 1'b1);
        total++;
        if ({mem_we, mem_wdata, mem_addr} !== {1'b1, 10'h2A, 10'd6}) begin
            bad++; $display("FAIL store_port got=%h exp=%h", {mem_we, mem_wdata, mem_addr}, {1'b1, 10'h2A, 10'd6});
        end
        ldi = mk(3'd0, 10'd6, 10'd0, 1'b1, 3'd6, 3'd3);
        ldi.mem_re = 1'b1;
        step(ldi, 1'b1);
        total++;
        if ({mem_we, mem_wdata} !== 11'd0) begin
            bad++; $display("FAIL load_port got=%h exp=%h", {mem_we, mem_wdata}, 11'd0);
        end
        step('0, 1'b1);
        total++;
        if ({wb_we, wb_dest, wb_wdata} !== {1'b1, 3'd3, 10'h2A}) begin
            bad++; $display("FAIL load_writeback got=%h exp=%h", {wb_we, wb_dest, wb_wdata}, {1'b1, 3'd3, 10'h2A});
        end
    endtask

    task automatic test_halt();
        step('0, 1'b1);
        step(mk(3'd6, 10'd0, 10'd0, 1'b0, 3'd0, 3'd0), 1'b1);
        total++;
        if (halted !== 1'b0) begin
            bad++; $display("FAIL halt_early got=%b exp=0", halted);
        end
        step(mk(3'd0, 10'd1, 10'd1, 1'b1, 3'd2, 3'd4), 1'b1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({halted, wb_we} !== 2'b10) begin
                bad++; $display("FAIL halt_hold%0d halted/wb_we got=%b exp=10", i, {halted, wb_we});
            end
            step(mk(3'd0, 10'(i), 10'd1, 1'b1, 3'd2, 3'd4), 1'b1);
        end
        step('0, 1'b0);
        total++;
        if (halted !== 1'b0) begin
            bad++; $display("FAIL halt_clear got=%b exp=0", halted);
        end
    endtask

    task automatic test_reset_mid();
        instr_t ldi;
        step('0, 1'b1);
        ldi = mk(3'd0, 10'd6, 10'd0, 1'b1, 3'd0, 3'd4);
        ldi.mem_re = 1'b1;
        step(ldi, 1'b1);
        step('0, 1'b0);
        total++;
        if (act_v !== 36'd0) begin
            bad++; $display("FAIL reset_mid got=%h exp=%h", act_v, 36'd0);
        end
        step('0, 1'b1);
        total++;
        if (wb_we !== 1'b0) begin
            bad++; $display("FAIL reset_mid_wb got=%b exp=0", wb_we);
        end
    endtask

    task automatic test_random();
        instr_t f;
        logic   rn;
        for (int i = 0; i < 400; i++) begin
            f = instr_t'({$urandom, $urandom});
            f.mem_we = ($urandom_range(0, 3) == 0);
            f.mem_re = ($urandom_range(0, 2) == 0);
            if (f.ctrl == 3'd6 && $urandom_range(0, 2) != 0) f.ctrl = 3'd0;
            rn = ($urandom_range(0, 40) != 0) && !(m_h && $urandom_range(0, 3) == 0);
            step(f, rn);
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL random%0d got=%h exp=%h", i, act_v, exp_v);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 10'($urandom);
            ref_mem[i] = mem[i];
        end
        m_em = '0; m_wb_we = 1'b0; m_wb_dest = '0; m_wb_data = '0; m_h = 1'b0;
        exp_v = '0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_store_load();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
